// File: rtl/radix4_gather_if.sv
// Stream interface for radix4_gather: serial complex samples in,
// parallel 4-sample groups out.
interface radix4_gather_if #(
  parameter int WIDTH = 45
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sof;
  logic [WIDTH-1:0] in_re;
  logic [WIDTH-1:0] in_im;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_r0;
  logic [WIDTH-1:0] out_r1;
  logic [WIDTH-1:0] out_r2;
  logic [WIDTH-1:0] out_r3;
  logic [WIDTH-1:0] out_i0;
  logic [WIDTH-1:0] out_i1;
  logic [WIDTH-1:0] out_i2;
  logic [WIDTH-1:0] out_i3;
  logic [7:0]       out_grp;
  logic             drop;

  modport master (
    output in_valid, in_sof, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_grp, drop,
    input  out_r0, out_r1, out_r2, out_r3,
    input  out_i0, out_i1, out_i2, out_i3
  );

  modport slave (
    input  in_valid, in_sof, in_re, in_im, out_ready,
    output in_ready, out_valid, out_grp, drop,
    output out_r0, out_r1, out_r2, out_r3,
    output out_i0, out_i1, out_i2, out_i3
  );
endinterface

// File: rtl/radix4_gather.sv
// Gathers serial complex samples into parallel 4-sample groups
// for a radix-4 butterfly, with a fill bank and an output bank.
module radix4_gather #(
  parameter int WIDTH = 45
) (
  input logic           clk,
  input logic           rst,
  radix4_gather_if.slave bus
);
  logic [1:0]       cnt;
  logic [1:0]       slot;
  logic             a_full;
  logic             acc;
  logic             done;
  logic             b_free;
  logic             vld_q;
  logic             drop_q;
  logic [7:0]       grp_q;
  logic [7:0]       fill_grp;
  logic [WIDTH-1:0] a_re [4];
  logic [WIDTH-1:0] a_im [4];
  logic [WIDTH-1:0] b_re [4];
  logic [WIDTH-1:0] b_im [4];

  assign acc    = bus.in_valid && !a_full;
  assign slot   = (acc && bus.in_sof) ? 2'd0 : cnt;
  assign done   = acc && (slot == 2'd3);
  assign b_free = !vld_q || bus.out_ready;

  assign bus.in_ready  = !a_full;
  assign bus.out_valid = vld_q;
  assign bus.out_grp   = grp_q;
  assign bus.drop      = drop_q;
  assign bus.out_r0    = b_re[0];
  assign bus.out_r1    = b_re[1];
  assign bus.out_r2    = b_re[2];
  assign bus.out_r3    = b_re[3];
  assign bus.out_i0    = b_im[0];
  assign bus.out_i1    = b_im[1];
  assign bus.out_i2    = b_im[2];
  assign bus.out_i3    = b_im[3];

  always_ff @(posedge clk) begin
    if (acc) begin
      a_re[slot] <= bus.in_re;
      a_im[slot] <= bus.in_im;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 2'd0;
      a_full   <= 1'b0;
      vld_q    <= 1'b0;
      drop_q   <= 1'b0;
      grp_q    <= 8'd0;
      fill_grp <= 8'd0;
      for (int k = 0; k < 4; k++) begin
        b_re[k] <= '0;
        b_im[k] <= '0;
      end
    end else begin
      drop_q <= acc && bus.in_sof && (cnt != 2'd0);
      if (acc) begin
        cnt <= slot + 2'd1;
        if (bus.in_sof)
          fill_grp <= 8'd0;
      end
      // fill_grp is numbered at B-load time; filling stalls while a_full
      if (done && b_free) begin
        for (int k = 0; k < 3; k++) begin
          b_re[k] <= a_re[k];
          b_im[k] <= a_im[k];
        end
        b_re[3]  <= bus.in_re;
        b_im[3]  <= bus.in_im;
        vld_q    <= 1'b1;
        grp_q    <= fill_grp;
        fill_grp <= fill_grp + 8'd1;
      end else if (done) begin
        a_full <= 1'b1;
      end else if (a_full && b_free) begin
        for (int k = 0; k < 4; k++) begin
          b_re[k] <= a_re[k];
          b_im[k] <= a_im[k];
        end
        vld_q    <= 1'b1;
        a_full   <= 1'b0;
        grp_q    <= fill_grp;
        fill_grp <= fill_grp + 8'd1;
      end else if (bus.out_ready) begin
        vld_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_radix4_gather.sv
// Scoreboard bench for radix4_gather: directed scenarios then a
// random handshake soak, expected groups queued as samples are accepted.
module tb_radix4_gather;
  localparam int W  = 45;
  localparam int GW = 8 + 8 * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  radix4_gather_if #(.WIDTH(W)) bus ();
  radix4_gather #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int drops  = 0;

  logic [GW-1:0] sb [$];
  logic [W-1:0]  m_re [4];
  logic [W-1:0]  m_im [4];
  int            m_cnt  = 0;
  logic [7:0]    m_grp  = 8'd0;
  logic          m_drop = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_cnt  = 0;
    m_grp  = 8'd0;
    m_drop = 1'b0;
  endtask

  task automatic step(input bit v, input bit sof, input logic [W-1:0] re,
                      input logic [W-1:0] im, input bit ordy,
                      output bit acc);
    logic [GW-1:0] e;
    logic [GW-1:0] o;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_sof    = sof;
    bus.in_re     = re;
    bus.in_im     = im;
    bus.out_ready = ordy;
    #1;
    check("drop", 64'(bus.drop), 64'(m_drop));
    if (bus.drop === 1'b1) drops++;
    m_drop = 1'b0;
    acc = v && (bus.in_ready === 1'b1);
    if (bus.out_valid === 1'b1 && ordy) begin
      check("group_expected", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        o = {bus.out_grp, bus.out_r0, bus.out_r1, bus.out_r2, bus.out_r3,
             bus.out_i0, bus.out_i1, bus.out_i2, bus.out_i3};
        checks++;
        assert (o === e) else begin
          errors++;
          $error("FAIL group observed=%0h expected=%0h", o, e);
        end
      end
    end
    if (acc) begin
      if (sof) begin
        m_drop = (m_cnt != 0);
        m_cnt  = 0;
        m_grp  = 8'd0;
      end
      m_re[m_cnt] = re;
      m_im[m_cnt] = im;
      if (m_cnt == 3) begin
        sb.push_back({m_grp, m_re[0], m_re[1], m_re[2], m_re[3],
                      m_im[0], m_im[1], m_im[2], m_im[3]});
        m_grp++;
      end
      m_cnt = (m_cnt + 1) % 4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_drop", 64'(bus.drop), 64'(0));
    check("rst_grp", 64'(bus.out_grp), 64'(0));
    check("rst_data", 64'(|{bus.out_r0, bus.out_r1, bus.out_r2, bus.out_r3,
                            bus.out_i0, bus.out_i1, bus.out_i2, bus.out_i3}),
          64'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bit acc;
    int n;
    int guard;
    int d0;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // back-to-back stream, zero-bubble
    for (int i = 1; i <= 8; i++) begin
      check("s1_in_ready", 64'(bus.in_ready), 64'(1));
      step(1'b1, i == 1, W'(i), W'(-i), 1'b1, acc);
      check("s1_acc", 64'(acc), 64'(1));
      if (i == 4 || i == 8) begin
        check("s1_latency", 64'(bus.out_valid), 64'(1));
        check("s1_grp", 64'(bus.out_grp), (i == 4) ? 64'(0) : 64'(1));
        check("s1_r3", 64'(bus.out_r3), 64'(i));
      end
    end
    step(1'b0, 1'b0, '0, '0, 1'b1, acc);

    // backpressure
    n = 0;
    guard = 0;
    while (n < 8 && guard < 20) begin
      step(1'b1, n == 0, W'(n + 1), W'(-(n + 1)), 1'b0, acc);
      if (acc) n++;
      guard++;
    end
    check("s2_accepted8", 64'(n), 64'(8));
    check("s2_in_ready_low", 64'(bus.in_ready), 64'(0));
    repeat (2) step(1'b1, 1'b0, W'(9), W'(-9), 1'b0, acc);
    check("s2_no_accept", 64'(acc), 64'(0));
    check("s2_hold_r0", 64'(bus.out_r0), 64'(1));
    check("s2_hold_grp", 64'(bus.out_grp), 64'(0));
    step(1'b1, 1'b0, W'(9), W'(-9), 1'b1, acc);
    check("s2_b_next", 64'(bus.out_r0), 64'(5));
    check("s2_b_grp", 64'(bus.out_grp), 64'(1));
    check("s2_in_ready_back", 64'(bus.in_ready), 64'(1));
    guard = 0;
    while (n < 12 && guard < 20) begin
      step(1'b1, 1'b0, W'(n + 1), W'(-(n + 1)), 1'b1, acc);
      if (acc) n++;
      guard++;
    end
    check("s2_accepted12", 64'(n), 64'(12));
    step(1'b0, 1'b0, '0, '0, 1'b1, acc);

    // SOF mid-group
    d0 = drops;
    step(1'b1, 1'b0, W'(20), W'(-20), 1'b1, acc);
    step(1'b1, 1'b0, W'(21), W'(-21), 1'b1, acc);
    for (int k = 0; k < 4; k++)
      step(1'b1, k == 0, W'(10 + k), W'(-(10 + k)), 1'b1, acc);
    check("s3_r0", 64'(bus.out_r0), 64'(10));
    check("s3_grp", 64'(bus.out_grp), 64'(0));
    step(1'b0, 1'b0, '0, '0, 1'b1, acc);
    check("s3_drop_count", 64'(drops - d0), 64'(1));

    // group index wrap
    for (int g = 0; g <= 256; g++) begin
      for (int k = 0; k < 4; k++)
        step(1'b1, g == 0 && k == 0, W'(g * 4 + k), W'(~(g * 4 + k)),
             1'b1, acc);
      if (g == 255) check("s4_grp255", 64'(bus.out_grp), 64'(255));
    end
    check("s4_wrap_valid", 64'(bus.out_valid), 64'(1));
    check("s4_wrap_grp", 64'(bus.out_grp), 64'(0));
    step(1'b0, 1'b0, '0, '0, 1'b1, acc);

    // reset with pending and partial groups
    for (int k = 0; k < 7; k++)
      step(1'b1, k == 0, W'(40 + k), W'(-(40 + k)), 1'b0, acc);
    check("s5_b_valid", 64'(bus.out_valid), 64'(1));
    do_reset();
    for (int k = 0; k < 4; k++)
      step(1'b1, 1'b0, W'(30 + k), W'(-(30 + k)), 1'b1, acc);
    check("s5_r0", 64'(bus.out_r0), 64'(30));
    check("s5_r3", 64'(bus.out_r3), 64'(33));
    check("s5_grp", 64'(bus.out_grp), 64'(0));
    step(1'b0, 1'b0, '0, '0, 1'b1, acc);

    // random handshake soak
    n = 0;
    guard = 0;
    while (n < 10000 && guard < 80000) begin
      step(bit'($urandom % 2), ($urandom % 64) == 0,
           W'({$urandom, $urandom}), W'({$urandom, $urandom}),
           bit'($urandom % 2), acc);
      if (acc) n++;
      guard++;
    end
    check("s6_accepted", 64'(n), 64'(10000));
    guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, acc);
      guard++;
    end
    check("s6_sb_empty", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
